// File: rtl/serial_frame_decoder_pkg.sv
// Shared constants, state encoding and error codes for the serial frame decoder.
// Imported by the interface, the buffer and the decoder top.
package serial_frame_pkg;

   localparam logic [7:0] SOF_BYTE   = 8'hFF;
   localparam logic [7:0] SPACE_BYTE = 8'h00;
   localparam logic [7:0] EOF_BYTE   = 8'hEE;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SOF2,
      S_SPACE,
      S_LEN,
      S_PAYLOAD,
      S_EOF1,
      S_EOF2,
      S_HOLD
   } state_t;

   localparam logic [2:0] ERR_NONE    = 3'd0;
   localparam logic [2:0] ERR_BYTE    = 3'd1;
   localparam logic [2:0] ERR_SPACE   = 3'd2;
   localparam logic [2:0] ERR_LEN     = 3'd3;
   localparam logic [2:0] ERR_EOF     = 3'd4;
   localparam logic [2:0] ERR_TIMEOUT = 3'd5;
   localparam logic [2:0] ERR_OVERRUN = 3'd6;

endpackage

// File: rtl/serial_frame_decoder_if.sv
// Byte-in / frame-out bundle between UART receiver, decoder and executor.
// master = upstream/executor side, slave = decoder side.
interface serial_frame_decoder_if #(
   parameter int MAX_PAYLOAD = 16
);
   localparam int AW = $clog2(MAX_PAYLOAD);

   logic [7:0]    byte_data;
   logic          byte_valid;
   logic          byte_err;
   logic          frame_valid;
   logic          frame_ack;
   logic [7:0]    payload_len;
   logic [AW-1:0] rd_addr;
   logic [7:0]    rd_data;
   logic          frame_err;
   logic [2:0]    err_code;

   modport master (
      output byte_data, byte_valid, byte_err,
      output frame_ack, rd_addr,
      input  frame_valid, payload_len, rd_data,
      input  frame_err, err_code
   );

   modport slave (
      input  byte_data, byte_valid, byte_err,
      input  frame_ack, rd_addr,
      output frame_valid, payload_len, rd_data,
      output frame_err, err_code
   );

endinterface

// File: rtl/serial_frame_buffer.sv
// Payload store: DEPTH x 8 registers, synchronous write, combinational read.
// Contents are not reset; only bytes below payload_len are ever read.
module serial_frame_buffer #(
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] wr_addr,
   input  logic [7:0]    wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data
);

   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/serial_frame_decoder.sv
// Parses FF FF 00 LEN payload EE EE frames and holds the payload for the executor.
// Define SERIAL_FRAME_TIMEOUT_EN to abort frames after TIMEOUT_TICKS idle clocks.
module serial_frame_decoder
   import serial_frame_pkg::*;
#(
   parameter int MAX_PAYLOAD   = 16,
   parameter int TIMEOUT_TICKS = 8680
) (
   input logic             clk,
   input logic             rst,
   serial_frame_decoder_if.slave bus
);

   localparam int AW = $clog2(MAX_PAYLOAD);

   state_t        state_q, state_d;
   logic [7:0]    len_q, len_d;
   logic [AW-1:0] idx_q, idx_d;
   logic          fv_q, fv_d;
   logic [7:0]    plen_q, plen_d;
   logic          err_q, err_d;
   logic [2:0]    code_q, code_d;
   logic          we;
   logic          in_frame;
   logic          tick_hit;

   assign in_frame = (state_q != S_IDLE) && (state_q != S_HOLD);

`ifdef SERIAL_FRAME_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_TICKS + 1);
   logic [CW-1:0] tick_q;

   assign tick_hit = in_frame && !bus.byte_valid &&
                     (tick_q == CW'(TIMEOUT_TICKS - 1));

   always_ff @(posedge clk) begin
      if (rst || !in_frame || bus.byte_valid || tick_hit)
         tick_q <= '0;
      else
         tick_q <= tick_q + CW'(1);
   end
`else
   assign tick_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         len_q   <= '0;
         idx_q   <= '0;
         fv_q    <= 1'b0;
         plen_q  <= '0;
         err_q   <= 1'b0;
         code_q  <= ERR_NONE;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         fv_q    <= fv_d;
         plen_q  <= plen_d;
         err_q   <= err_d;
         code_q  <= code_d;
      end
   end

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      idx_d   = idx_q;
      fv_d    = fv_q;
      plen_d  = plen_q;
      err_d   = 1'b0;
      code_d  = ERR_NONE;
      we      = 1'b0;
      // Erroring byte is consumed; the next byte starts SOF search afresh
      if (bus.byte_valid && bus.byte_err && in_frame) begin
         err_d   = 1'b1;
         code_d  = ERR_BYTE;
         state_d = S_IDLE;
      end else if (bus.byte_valid) begin
         case (state_q)
            S_IDLE: begin
               if (!bus.byte_err && bus.byte_data == SOF_BYTE)
                  state_d = S_SOF2;
            end
            S_SOF2: begin
               state_d = (bus.byte_data == SOF_BYTE) ? S_SPACE : S_IDLE;
            end
            S_SPACE: begin
               if (bus.byte_data == SPACE_BYTE) begin
                  state_d = S_LEN;
               end else begin
                  err_d   = 1'b1;
                  code_d  = ERR_SPACE;
                  state_d = S_IDLE;
               end
            end
            S_LEN: begin
               if (bus.byte_data == 8'd0) begin
                  len_d   = '0;
                  state_d = S_EOF1;
               end else if (bus.byte_data <= 8'(MAX_PAYLOAD)) begin
                  len_d   = bus.byte_data;
                  idx_d   = '0;
                  state_d = S_PAYLOAD;
               end else begin
                  err_d   = 1'b1;
                  code_d  = ERR_LEN;
                  state_d = S_IDLE;
               end
            end
            S_PAYLOAD: begin
               we    = 1'b1;
               idx_d = idx_q + AW'(1);
               if (8'(idx_q) == len_q - 8'd1) state_d = S_EOF1;
            end
            S_EOF1, S_EOF2: begin
               if (bus.byte_data != EOF_BYTE) begin
                  err_d   = 1'b1;
                  code_d  = ERR_EOF;
                  state_d = S_IDLE;
               end else if (state_q == S_EOF1) begin
                  state_d = S_EOF2;
               end else begin
                  state_d = S_HOLD;
                  fv_d    = 1'b1;
                  plen_d  = len_q;
               end
            end
            S_HOLD: begin
               if (!(bus.frame_ack && fv_q)) begin
                  err_d  = 1'b1;
                  code_d = ERR_OVERRUN;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end else if (tick_hit) begin
         err_d   = 1'b1;
         code_d  = ERR_TIMEOUT;
         state_d = S_IDLE;
      end
      // Ack beats a same-cycle byte in HOLD; that byte is dropped silently
      if (state_q == S_HOLD && bus.frame_ack && fv_q) begin
         fv_d    = 1'b0;
         state_d = S_IDLE;
      end
   end

   serial_frame_buffer #(.DEPTH(MAX_PAYLOAD)) u_buf (
      .clk     (clk),
      .we      (we),
      .wr_addr (idx_q),
      .wr_data (bus.byte_data),
      .rd_addr (bus.rd_addr),
      .rd_data (bus.rd_data)
   );

   assign bus.frame_valid = fv_q;
   assign bus.payload_len = plen_q;
   assign bus.frame_err   = err_q;
   assign bus.err_code    = code_q;

endmodule

// File: tb/tb_serial_frame_decoder.sv
// Directed-vector bench for serial_frame_decoder.
// Build with SERIAL_FRAME_TIMEOUT_EN to exercise the timeout path.
module tb_serial_frame_decoder;
   import serial_frame_pkg::*;

   localparam int MAXP = 16;
   localparam int TO   = 8680;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   serial_frame_decoder_if #(.MAX_PAYLOAD(MAXP)) bus ();

   serial_frame_decoder #(
      .MAX_PAYLOAD   (MAXP),
      .TIMEOUT_TICKS (TO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_vec  = 0;
   int n_bad  = 0;
   int n_err  = 0;
   int n_wide = 0;
   int e0;
   logic [2:0] last_code = 3'd0;
   logic err_prev = 1'b0;
   logic [7:0] fq[$];

   always @(negedge clk) begin
      if (bus.frame_err) begin
         n_err++;
         last_code = bus.err_code;
         if (err_prev) n_wide++;
      end
      err_prev = bus.frame_err;
   end

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [7:0] b, input logic e = 1'b0);
      @(negedge clk);
      bus.byte_data  = b;
      bus.byte_valid = 1'b1;
      bus.byte_err   = e;
      @(negedge clk);
      bus.byte_valid = 1'b0;
      bus.byte_err   = 1'b0;
      #1;
   endtask

   task automatic send_q();
      foreach (fq[i]) send(fq[i]);
   endtask

   task automatic ack();
      @(negedge clk);
      bus.frame_ack = 1'b1;
      @(negedge clk);
      bus.frame_ack = 1'b0;
      #1;
   endtask

   task automatic rd(input string tag, input int a, input logic [7:0] exp);
      bus.rd_addr = 4'(a);
      #1;
      chk(tag, {24'd0, bus.rd_data}, {24'd0, exp});
   endtask

   initial begin
      bus.byte_data  = 8'h00;
      bus.byte_valid = 1'b0;
      bus.byte_err   = 1'b0;
      bus.frame_ack  = 1'b0;
      bus.rd_addr    = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_fv",   32'(bus.frame_valid), 0);
      chk("rst_len",  32'(bus.payload_len), 0);
      chk("rst_err",  32'(bus.frame_err),   0);
      chk("rst_code", 32'(bus.err_code),    0);
      rst = 1'b0;

      // basic two-byte frame, ack after 5 cycles
      e0 = n_err;
      fq = {8'hFF, 8'hFF, 8'h00, 8'h02, 8'h02, 8'h03, 8'hEE, 8'hEE};
      send_q();
      chk("f1_fv",  32'(bus.frame_valid), 1);
      chk("f1_len", 32'(bus.payload_len), 2);
      rd("f1_rd0", 0, 8'h02);
      rd("f1_rd1", 1, 8'h03);
      repeat (5) @(negedge clk);
      #1;
      chk("f1_fv_hold", 32'(bus.frame_valid), 1);
      ack();
      chk("f1_fv_ack", 32'(bus.frame_valid), 0);
      chk("f1_noerr",  32'(n_err), 32'(e0));

      // zero-length frame
      fq = {8'hFF, 8'hFF, 8'h00, 8'h00, 8'hEE, 8'hEE};
      send_q();
      chk("f0_fv",  32'(bus.frame_valid), 1);
      chk("f0_len", 32'(bus.payload_len), 0);
      chk("f0_noerr", 32'(n_err), 32'(e0));
      ack();

      // bad EOF then a good frame
      fq = {8'hFF, 8'hFF, 8'h00, 8'h02, 8'h02, 8'h03, 8'hEE, 8'h11};
      send_q();
      chk("eof_cnt",  32'(n_err), 32'(e0 + 1));
      chk("eof_code", 32'(last_code), 32'(ERR_EOF));
      chk("eof_fv",   32'(bus.frame_valid), 0);
      fq = {8'hFF, 8'hFF, 8'h00, 8'h01, 8'h05, 8'hEE, 8'hEE};
      send_q();
      chk("rec_fv",  32'(bus.frame_valid), 1);
      chk("rec_len", 32'(bus.payload_len), 1);
      rd("rec_rd0", 0, 8'h05);
      ack();

      // length above MAX_PAYLOAD
      e0 = n_err;
      fq = {8'hFF, 8'hFF, 8'h00, 8'h11};
      send_q();
      chk("len_cnt",  32'(n_err), 32'(e0 + 1));
      chk("len_code", 32'(last_code), 32'(ERR_LEN));

      // byte_err inside payload
      fq = {8'hFF, 8'hFF, 8'h00, 8'h02};
      send_q();
      send(8'h03, 1'b1);
      chk("berr_cnt",  32'(n_err), 32'(e0 + 2));
      chk("berr_code", 32'(last_code), 32'(ERR_BYTE));

      // bad space byte
      fq = {8'hFF, 8'hFF, 8'h01};
      send_q();
      chk("sp_cnt",  32'(n_err), 32'(e0 + 3));
      chk("sp_code", 32'(last_code), 32'(ERR_SPACE));

      // erroring 0xFF is not a new SOF
      fq = {8'hFF, 8'hFF, 8'h00, 8'h01, 8'h07, 8'hFF};
      send_q();
      chk("resof_code", 32'(last_code), 32'(ERR_EOF));
      fq = {8'hFF, 8'hFF, 8'h00, 8'h01, 8'h06, 8'hEE, 8'hEE};
      send_q();
      chk("resof_cnt", 32'(n_err), 32'(e0 + 4));
      chk("resof_fv",  32'(bus.frame_valid), 1);
      rd("resof_rd0", 0, 8'h06);
      ack();

      // silent garbage in IDLE/SOF2, and byte_err ignored in IDLE
      e0 = n_err;
      send(8'h12);
      send(8'hFF);
      send(8'h34);
      send(8'hFF, 1'b1);
      fq = {8'hFF, 8'hFF, 8'h00, 8'h01, 8'h09, 8'hEE, 8'hEE};
      send_q();
      chk("idle_noerr", 32'(n_err), 32'(e0));
      chk("idle_fv",    32'(bus.frame_valid), 1);
      rd("idle_rd0", 0, 8'h09);

      // overrun while holding a frame
      ack();
      fq = {8'hFF, 8'hFF, 8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hEE, 8'hEE};
      send_q();
      send(8'h55);
      chk("ovr_cnt",  32'(n_err), 32'(e0 + 1));
      chk("ovr_code", 32'(last_code), 32'(ERR_OVERRUN));
      chk("ovr_fv",   32'(bus.frame_valid), 1);
      chk("ovr_len",  32'(bus.payload_len), 3);
      rd("ovr_rd0", 0, 8'hAA);
      rd("ovr_rd1", 1, 8'hBB);
      rd("ovr_rd2", 2, 8'hCC);

      // same-cycle ack and byte: ack wins, no overrun
      @(negedge clk);
      bus.frame_ack  = 1'b1;
      bus.byte_data  = 8'hFF;
      bus.byte_valid = 1'b1;
      @(negedge clk);
      bus.frame_ack  = 1'b0;
      bus.byte_valid = 1'b0;
      #1;
      chk("race_fv",  32'(bus.frame_valid), 0);
      chk("race_cnt", 32'(n_err), 32'(e0 + 1));

      // full MAX_PAYLOAD frame
      fq = {8'hFF, 8'hFF, 8'h00, 8'h10};
      for (int i = 0; i < MAXP; i++) fq.push_back(8'(8'h20 + i));
      fq.push_back(8'hEE);
      fq.push_back(8'hEE);
      send_q();
      chk("max_fv",  32'(bus.frame_valid), 1);
      chk("max_len", 32'(bus.payload_len), 16);
      rd("max_rd0",  0,  8'h20);
      rd("max_rd15", 15, 8'h2F);
      chk("max_noerr", 32'(n_err), 32'(e0 + 1));
      ack();

      // reset mid-frame
      fq = {8'hFF, 8'hFF, 8'h00, 8'h02, 8'h01};
      send_q();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mrst_fv", 32'(bus.frame_valid), 0);
      fq = {8'hFF, 8'hFF, 8'h00, 8'h01, 8'h0A, 8'hEE, 8'hEE};
      send_q();
      chk("mrst_cnt", 32'(n_err), 32'(e0 + 1));
      chk("mrst_fv2", 32'(bus.frame_valid), 1);
      rd("mrst_rd0", 0, 8'h0A);
      ack();

      // inter-byte silence
      e0 = n_err;
      fq = {8'hFF, 8'hFF, 8'h00};
      send_q();
`ifdef SERIAL_FRAME_TIMEOUT_EN
      repeat (TO - 1) @(negedge clk);
      #1;
      chk("to_early", 32'(n_err), 32'(e0));
      @(negedge clk);
      #1;
      chk("to_hit",  32'(n_err), 32'(e0 + 1));
      chk("to_code", 32'(last_code), 32'(ERR_TIMEOUT));
`else
      repeat (TO + 20) @(negedge clk);
      #1;
      chk("to_none", 32'(n_err), 32'(e0));
      fq = {8'h01, 8'h07, 8'hEE, 8'hEE};
      send_q();
      chk("to_fv", 32'(bus.frame_valid), 1);
      rd("to_rd0", 0, 8'h07);
      ack();
`endif

      chk("pulse_width", 32'(n_wide), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
